// File: rtl/fourx1_mux_if.sv
// fourx1_mux_if: operand/select bus and registered result bus for fourx1_mux (y_parity only with FOURX1_MUX_PARITY_EN)
interface fourx1_mux_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] c;
  logic [DATA_WIDTH-1:0] d;
  logic [1:0]            sel;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] y;
  logic                  out_valid;
  logic [1:0]            y_sel;
`ifdef FOURX1_MUX_PARITY_EN
  logic                  y_parity;
  modport master (output a, b, c, d, sel, in_valid, input y, out_valid, y_sel, y_parity);
  modport slave  (input a, b, c, d, sel, in_valid, output y, out_valid, y_sel, y_parity);
`else
  modport master (output a, b, c, d, sel, in_valid, input y, out_valid, y_sel);
  modport slave  (input a, b, c, d, sel, in_valid, output y, out_valid, y_sel);
`endif
endinterface

// File: rtl/fourx1_mux.sv
// fourx1_mux: registered 4-to-1 mux with valid qualifier; FOURX1_MUX_PARITY_EN adds y_parity = ^y
module fourx1_mux #(
  parameter int DATA_WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  fourx1_mux_if.slave bus
);
  logic [DATA_WIDTH-1:0] pick;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [1:0]            y_sel_q, y_sel_d;
  logic                  out_valid_q, out_valid_d;
  // Select tree keyed only on sel, so an X on an unselected operand never reaches y; y and y_sel hold when idle
  always_comb begin
    pick        = bus.sel[1] ? (bus.sel[0] ? bus.d : bus.c) : (bus.sel[0] ? bus.b : bus.a);
    y_d         = bus.in_valid ? pick : y_q;
    y_sel_d     = bus.in_valid ? bus.sel : y_sel_q;
    out_valid_d = bus.in_valid;
  end
  // Output register; reset wins over in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      y_sel_q     <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      y_sel_q     <= y_sel_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.y         = y_q;
  assign bus.y_sel     = y_sel_q;
  assign bus.out_valid = out_valid_q;
`ifdef FOURX1_MUX_PARITY_EN
  assign bus.y_parity  = ^y_q;
`endif
endmodule

// File: tb/tb_fourx1_mux.sv
// tb_fourx1_mux: directed scoreboard bench for fourx1_mux at widths 4 and 8
module tb_fourx1_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fourx1_mux_if #(.DATA_WIDTH(4)) bus4 ();
  fourx1_mux_if #(.DATA_WIDTH(8)) bus8 ();
  fourx1_mux #(.DATA_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  fourx1_mux #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  typedef struct packed {
    logic [3:0] y;
    logic [1:0] s;
    logic       v;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic iv, input logic [1:0] s,
                      input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic, input logic [3:0] id);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus4.in_valid = iv;
    bus4.sel = s;
    bus4.a = ia;
    bus4.b = ib;
    bus4.c = ic;
    bus4.d = id;
    if (r) m = '0;
    else if (iv) begin
      case (s)
        2'b00: m.y = ia;
        2'b01: m.y = ib;
        2'b10: m.y = ic;
        default: m.y = id;
      endcase
      m.s = s;
      m.v = 1'b1;
    end else m.v = 1'b0;
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("y", {4'b0, bus4.y}, {4'b0, e.y});
    chk("y_sel", {6'b0, bus4.y_sel}, {6'b0, e.s});
    chk("out_valid", {7'b0, bus4.out_valid}, {7'b0, e.v});
`ifdef FOURX1_MUX_PARITY_EN
    chk("y_parity", {7'b0, bus4.y_parity}, {7'b0, ^e.y});
`endif
  endtask
  initial begin
    m = '0;
    bus8.in_valid = 1'b0;
    bus8.sel = 2'b00;
    bus8.a = '0;
    bus8.b = '0;
    bus8.c = '0;
    bus8.d = '0;
    step(1, 1, 2'b00, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(1, 1, 2'b00, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b00, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b01, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b10, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 0, 2'b11, 4'b0110, 4'b1010, 4'b1001, 4'b1111);
    step(0, 0, 2'b00, 4'b0110, 4'b1010, 4'b1001, 4'b1111);
    step(0, 1, 2'b11, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b00, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(1, 1, 2'b01, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b10, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b11, 4'b0110, 4'b1010, 4'b1001, 4'b0101);
    step(0, 1, 2'b00, 4'bxxxx, 4'b0011, 4'bxxxx, 4'bxxxx);
    step(0, 1, 2'b01, 4'b0110, 4'bxxxx, 4'bxxxx, 4'bxxxx);
    step(0, 1, 2'b00, 4'b0110, 4'bxxxx, 4'bxxxx, 4'bxxxx);
    for (int i = 0; i < 4; i++) step(0, 1, i[1:0], 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 2'b01, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
    step(0, 1, 2'b00, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus8.a = 8'hA5;
    bus8.d = 8'h3C;
    bus8.sel = 2'b00;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_y_a", bus8.y, 8'hA5);
    chk("w8_valid", {7'b0, bus8.out_valid}, 8'h01);
    @(negedge clk);
    bus8.sel = 2'b11;
    @(posedge clk);
    #1;
    chk("w8_y_d", bus8.y, 8'h3C);
    chk("w8_sel", {6'b0, bus8.y_sel}, 8'h03);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.sel = 2'b00;
    @(posedge clk);
    #1;
    chk("w8_hold", bus8.y, 8'h3C);
    chk("w8_idle", {7'b0, bus8.out_valid}, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
